uart_imem_loader: RTL and testbench

- Hardware bootloader and serial responder on the far end of the CPU's UART link.
- Receives a framed program image on serial_in and writes it word-by-word into IMEM through IMEM port A.
- Replies with ACK/NAK on serial_out and holds the CPU while a load is in progress.
- Lets new IMEM images be loaded without the BIOS running.

---
 rtl/uart_imem_loader_if.sv | 12 +
 rtl/uart_imem_loader.sv | 187 ++++++++++++++++++
 tb/tb_uart_imem_loader.sv | 241 ++++++++++++++++++++++++
 3 files changed

// File: rtl/uart_imem_loader_if.sv
// IMEM port A write bus driven by the UART bootloader.
interface uart_imem_loader_if #(
  parameter int unsigned IMEM_AW = 14
);
  logic               imem_en;
  logic [3:0]         imem_we;
  logic [IMEM_AW-1:0] imem_addr;
  logic [31:0]        imem_din;

  modport master (output imem_en, output imem_we, output imem_addr, output imem_din);
  modport slave  (input  imem_en, input  imem_we, input  imem_addr, input  imem_din);
endinterface

// File: rtl/uart_imem_loader.sv
// UART bootloader: receives framed images, writes IMEM port A, answers ACK/NAK.
// Optional receive timeout enabled by defining UART_LOADER_TIMEOUT_EN.
module uart_imem_loader #(
  parameter int unsigned CLOCK_FREQ = 50_000_000,
  parameter int unsigned BAUD_RATE  = 115200,
  parameter int unsigned IMEM_AW    = 14
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                serial_in,
  output logic                serial_out,
  uart_imem_loader_if.master  imem,
  output logic                cpu_hold,
  output logic                load_done,
  output logic                load_err
);
  localparam int unsigned CLKS_PER_BIT = CLOCK_FREQ / BAUD_RATE;
  localparam int unsigned CW = $clog2(CLKS_PER_BIT + 1);
  localparam logic [CW-1:0] BIT_END  = CW'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0] HALF_END = CW'(CLKS_PER_BIT / 2 - 1);

  typedef enum logic [2:0] {IDLE, ADDR, CNT, DATA, CSUM, RESP} state_t;
  state_t state, state_n;

  // ---------------- receiver ----------------
  logic          rx_s1, rx_s2, rx_prev, rx_busy, rx_valid, rx_frame_err;
  logic [CW-1:0] rx_cnt;
  logic [3:0]    rx_bit;
  logic [7:0]    rx_data;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rx_s1 <= 1'b1; rx_s2 <= 1'b1; rx_prev <= 1'b1;
      rx_busy <= 1'b0; rx_cnt <= '0; rx_bit <= '0; rx_data <= '0;
      rx_valid <= 1'b0; rx_frame_err <= 1'b0;
    end else begin
      rx_s1 <= serial_in; rx_s2 <= rx_s1; rx_prev <= rx_s2;
      rx_valid <= 1'b0; rx_frame_err <= 1'b0;
      if (!rx_busy) begin
        if (rx_prev && !rx_s2) begin
          rx_busy <= 1'b1; rx_cnt <= '0; rx_bit <= '0;
        end
      end else if (rx_bit == 4'd0) begin
        // start bit re-checked at half a bit; a high line here was a glitch
        if (rx_cnt == HALF_END) begin
          rx_cnt <= '0;
          if (rx_s2) rx_busy <= 1'b0;
          else       rx_bit  <= 4'd1;
        end else rx_cnt <= rx_cnt + 1'b1;
      end else if (rx_cnt == BIT_END) begin
        rx_cnt <= '0;
        if (rx_bit == 4'd9) begin
          rx_busy <= 1'b0;
          if (rx_s2) rx_valid <= 1'b1;
          else       rx_frame_err <= 1'b1;
        end else begin
          rx_data <= {rx_s2, rx_data[7:1]};
          rx_bit  <= rx_bit + 1'b1;
        end
      end else rx_cnt <= rx_cnt + 1'b1;
    end
  end

  // ---------------- transmitter ----------------
  logic          tx_busy, tx_start, tx_done;
  logic [7:0]    tx_byte;
  logic [9:0]    tx_frame;
  logic [CW-1:0] tx_cnt;
  logic [3:0]    tx_bit;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tx_busy <= 1'b0; tx_frame <= '1; tx_cnt <= '0; tx_bit <= '0; tx_done <= 1'b0;
    end else begin
      tx_done <= 1'b0;
      if (tx_start) begin
        tx_busy <= 1'b1; tx_frame <= {1'b1, tx_byte, 1'b0}; tx_cnt <= '0; tx_bit <= '0;
      end else if (tx_busy) begin
        if (tx_cnt == BIT_END) begin
          tx_cnt   <= '0;
          tx_frame <= {1'b1, tx_frame[9:1]};
          if (tx_bit == 4'd9) begin
            tx_busy <= 1'b0; tx_done <= 1'b1;
          end else tx_bit <= tx_bit + 1'b1;
        end else tx_cnt <= tx_cnt + 1'b1;
      end
    end
  end

  // the frame register refills with ones, so bit 0 is the idle-high line too
  assign serial_out = tx_frame[0];

  // ---------------- frame FSM ----------------
  logic               in_frame, timeout, start_frame, word_wr, ack_ok;
  logic [1:0]         byte_idx;
  logic [23:0]        addr_sh, word_sh;
  logic [7:0]         cnt_lo, csum;
  logic [15:0]        words_left;
  logic [IMEM_AW-1:0] ptr, addr_q;
  logic [31:0]        din_q;
  logic               en_q, resp_ack;

  assign in_frame = state inside {ADDR, CNT, DATA, CSUM};

`ifdef UART_LOADER_TIMEOUT_EN
  localparam int unsigned TO_CYCLES = 16 * 10 * CLKS_PER_BIT;
  localparam int unsigned TW = $clog2(TO_CYCLES + 1);
  logic [TW-1:0] to_cnt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst)                       to_cnt <= '0;
    else if (rx_valid || !in_frame) to_cnt <= '0;
    else if (!timeout)             to_cnt <= to_cnt + 1'b1;
  end
  assign timeout = in_frame && (to_cnt == TW'(TO_CYCLES - 1));
`else
  assign timeout = 1'b0;
`endif

  always_comb begin
    state_n = state; tx_start = 1'b0; tx_byte = 8'h15;
    start_frame = 1'b0; word_wr = 1'b0; ack_ok = 1'b0;
    case (state)
      IDLE: if (rx_valid && rx_data == 8'hA5) begin state_n = ADDR; start_frame = 1'b1; end
      ADDR: if (rx_valid && byte_idx == 2'd3) state_n = CNT;
      CNT:  if (rx_valid && byte_idx[0]) state_n = ({rx_data, cnt_lo} == 16'd0) ? CSUM : DATA;
      DATA: if (rx_valid && byte_idx == 2'd3) begin
              word_wr = 1'b1;
              if (words_left == 16'd1) state_n = CSUM;
            end
      CSUM: if (rx_valid) begin
              state_n = RESP; tx_start = 1'b1;
              if (rx_data == csum) begin ack_ok = 1'b1; tx_byte = 8'h06; end
            end
      RESP: if (tx_done) state_n = IDLE;
      default: state_n = IDLE;
    endcase
    if (in_frame && (rx_frame_err || timeout)) begin
      state_n = RESP; tx_start = 1'b1; tx_byte = 8'h15; ack_ok = 1'b0; word_wr = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE; byte_idx <= '0; addr_sh <= '0; word_sh <= '0; cnt_lo <= '0;
      csum <= '0; words_left <= '0; ptr <= '0; addr_q <= '0; din_q <= '0;
      en_q <= 1'b0; resp_ack <= 1'b0; cpu_hold <= 1'b0; load_done <= 1'b0; load_err <= 1'b0;
    end else begin
      state <= state_n; en_q <= 1'b0; load_done <= 1'b0;
      if (start_frame) begin
        cpu_hold <= 1'b1; load_err <= 1'b0; csum <= '0; byte_idx <= '0;
      end else if (rx_valid && state inside {ADDR, CNT, DATA} && state_n != RESP) begin
        csum <= csum + rx_data; byte_idx <= byte_idx + 1'b1;
        case (state)
          ADDR: begin
            addr_sh <= {rx_data, addr_sh[23:8]};
            if (byte_idx == 2'd3) ptr <= IMEM_AW'({rx_data, addr_sh} >> 2);
          end
          CNT: begin
            cnt_lo <= rx_data;
            if (byte_idx[0]) begin words_left <= {rx_data, cnt_lo}; byte_idx <= '0; end
          end
          DATA: begin
            word_sh <= {rx_data, word_sh[23:8]};
            if (word_wr) begin
              en_q <= 1'b1; addr_q <= ptr; din_q <= {rx_data, word_sh};
              ptr <= ptr + 1'b1; words_left <= words_left - 16'd1;
            end
          end
          default: ;
        endcase
      end
      if (tx_start) begin
        resp_ack <= ack_ok;
        if (!ack_ok) load_err <= 1'b1;
      end
      if (state == RESP && tx_done) begin
        cpu_hold <= 1'b0; load_done <= resp_ack;
      end
    end
  end

  assign imem.imem_en   = en_q;
  assign imem.imem_we   = en_q ? 4'hF : '0;
  assign imem.imem_addr = addr_q;
  assign imem.imem_din  = din_q;
endmodule

// File: tb/tb_uart_imem_loader.sv
// Bench for uart_imem_loader: table frames, random frames against a frame model, corner cases.
module tb_uart_imem_loader;
  localparam int unsigned CPB = 10;
  localparam int unsigned AW  = 14;

  logic clk = 1'b0;
  logic rst, serial_in, serial_out, cpu_hold, load_done, load_err;

  uart_imem_loader_if #(.IMEM_AW(AW)) bus ();

  uart_imem_loader #(.CLOCK_FREQ(1_000_000), .BAUD_RATE(100_000), .IMEM_AW(AW)) dut (
    .clk(clk), .rst(rst), .serial_in(serial_in), .serial_out(serial_out),
    .imem(bus), .cpu_hold(cpu_hold), .load_done(load_done), .load_err(load_err)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  logic [AW-1:0] wr_a_q[$];
  logic [31:0]   wr_d_q[$];
  logic [7:0]    tx_q[$];
  int            done_cnt = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (rst === 1'b0) begin
      if (bus.imem_en === 1'b1) begin
        wr_a_q.push_back(bus.imem_addr);
        wr_d_q.push_back(bus.imem_din);
        chk("imem_we", {28'd0, bus.imem_we}, 32'hF);
      end
      if (load_done === 1'b1) done_cnt++;
    end
  end

  // serial_out receiver: decodes whole bytes from the line
  initial begin
    forever begin
      @(negedge clk);
      if (rst === 1'b0 && serial_out === 1'b0) begin
        logic [7:0] b;
        repeat (CPB / 2) @(negedge clk);
        chk("tx_start_bit", {31'd0, serial_out}, 32'd0);
        for (int i = 0; i < 8; i++) begin
          repeat (CPB) @(negedge clk);
          b[i] = serial_out;
        end
        repeat (CPB) @(negedge clk);
        chk("tx_stop_bit", {31'd0, serial_out}, 32'd1);
        tx_q.push_back(b);
      end
    end
  end

  task automatic send_byte(input logic [7:0] b, input bit bad_stop);
    serial_in = 1'b0;
    repeat (CPB) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      serial_in = b[i];
      repeat (CPB) @(negedge clk);
    end
    serial_in = bad_stop ? 1'b0 : 1'b1;
    repeat (CPB) @(negedge clk);
    serial_in = 1'b1;
    repeat (2) @(negedge clk);
  endtask

  task automatic send_word(input logic [31:0] w, input int nbytes);
    for (int i = 0; i < nbytes; i++) send_byte(8'((w >> (8 * i)) & 32'hFF), 1'b0);
  endtask

  function automatic logic [7:0] frame_sum(input logic [31:0] addr, input logic [15:0] cnt,
                                           input logic [31:0] w[$]);
    int unsigned s = 0;
    for (int i = 0; i < 4; i++) s += (addr >> (8 * i)) & 32'hFF;
    s += cnt & 16'hFF;
    s += cnt >> 8;
    foreach (w[k]) for (int i = 0; i < 4; i++) s += (w[k] >> (8 * i)) & 32'hFF;
    return 8'(s % 256);
  endfunction

  task automatic clear_obs();
    wr_a_q.delete(); wr_d_q.delete(); tx_q.delete(); done_cnt = 0;
  endtask

  task automatic wait_resp(input int budget);
    int n = 0;
    while (tx_q.size() == 0 && n < budget) begin @(negedge clk); n++; end
    chk("resp_seen", tx_q.size(), 1);
    n = 0;
    while (cpu_hold !== 1'b0 && n < 100) begin @(negedge clk); n++; end
    repeat (4) @(negedge clk);
  endtask

  task automatic run_frame(input logic [31:0] addr, input logic [15:0] cnt, input logic [31:0] w[$],
                           input logic [7:0] csum, input bit garbage, input logic [7:0] exp_resp,
                           input logic [AW-1:0] exp_a[$]);
    clear_obs();
    if (garbage) begin
      send_byte(8'h00, 1'b0);
      send_byte(8'hFF, 1'b0);
      chk("hold_after_garbage", {31'd0, cpu_hold}, 32'd0);
    end
    send_byte(8'hA5, 1'b0);
    chk("hold_after_sync", {31'd0, cpu_hold}, 32'd1);
    chk("err_cleared_by_sync", {31'd0, load_err}, 32'd0);
    send_word(addr, 4);
    send_word({16'd0, cnt}, 2);
    foreach (w[k]) send_word(w[k], 4);
    send_byte(csum, 1'b0);
    wait_resp(400);
    if (tx_q.size() > 0) chk("resp_byte", tx_q[0], exp_resp);
    chk("hold_released", {31'd0, cpu_hold}, 32'd0);
    chk("write_count", wr_a_q.size(), exp_a.size());
    foreach (exp_a[i]) if (i < wr_a_q.size()) begin
      chk("write_addr", wr_a_q[i], exp_a[i]);
      chk("write_data", wr_d_q[i], w[i]);
    end
    chk("load_done_pulses", done_cnt, (exp_resp == 8'h06) ? 1 : 0);
    chk("load_err", {31'd0, load_err}, (exp_resp == 8'h15) ? 1 : 0);
    repeat (50) @(negedge clk);
    chk("load_err_sticky", {31'd0, load_err}, (exp_resp == 8'h15) ? 1 : 0);
    chk("no_extra_tx", tx_q.size(), 1);
  endtask

  typedef struct {
    logic [31:0]   addr;
    logic [15:0]   cnt;
    logic [31:0]   w0, w1;
    logic [7:0]    csum;
    bit            garbage;
    logic [7:0]    resp;
    logic [AW-1:0] a0, a1;
  } vec_t;

  vec_t          tbl[4];
  logic [31:0]   wq[$];
  logic [AW-1:0] aq[$];

  initial begin
    tbl[0] = '{32'h0, 16'd2, 32'h13, 32'h6F, 8'h84, 1'b0, 8'h06, 14'h0, 14'h1};
    tbl[1] = '{32'h0, 16'd2, 32'h13, 32'h6F, 8'h85, 1'b0, 8'h15, 14'h0, 14'h1};
    tbl[2] = '{32'h0000FFFC, 16'd2, 32'h11223344, 32'hA5A5A5A5, 8'h3B, 1'b0, 8'h06, 14'h3FFF, 14'h0};
    tbl[3] = '{32'h0, 16'd0, 32'h0, 32'h0, 8'h00, 1'b1, 8'h06, 14'h0, 14'h0};

    rst = 1'b1; serial_in = 1'b1;
    repeat (5) @(negedge clk);
    chk("rst_serial_out", {31'd0, serial_out}, 32'd1);
    chk("rst_imem_en", {31'd0, bus.imem_en}, 32'd0);
    chk("rst_imem_we", {28'd0, bus.imem_we}, 32'd0);
    chk("rst_imem_addr", {18'd0, bus.imem_addr}, 32'd0);
    chk("rst_imem_din", bus.imem_din, 32'd0);
    chk("rst_cpu_hold", {31'd0, cpu_hold}, 32'd0);
    chk("rst_load_done", {31'd0, load_done}, 32'd0);
    chk("rst_load_err", {31'd0, load_err}, 32'd0);
    rst = 1'b0;
    repeat (3000) @(negedge clk);
    chk("idle_no_writes", wr_a_q.size(), 0);
    chk("idle_no_tx", tx_q.size(), 0);

    for (int t = 0; t < 4; t++) begin
      wq.delete(); aq.delete();
      if (tbl[t].cnt > 0) begin wq.push_back(tbl[t].w0); aq.push_back(tbl[t].a0); end
      if (tbl[t].cnt > 1) begin wq.push_back(tbl[t].w1); aq.push_back(tbl[t].a1); end
      run_frame(tbl[t].addr, tbl[t].cnt, wq, tbl[t].csum, tbl[t].garbage, tbl[t].resp, aq);
    end

    for (int r = 0; r < 6; r++) begin
      logic [31:0] addr;
      logic [15:0] cnt;
      logic [7:0]  s;
      bit          bad;
      addr = $urandom;
      cnt  = 16'($urandom_range(0, 3));
      wq.delete(); aq.delete();
      for (int i = 0; i < int'(cnt); i++) begin
        wq.push_back($urandom);
        aq.push_back(AW'(((addr >> 2) + i) % (1 << AW)));
      end
      s   = frame_sum(addr, cnt, wq);
      bad = ($urandom_range(0, 3) == 0);
      if (bad) s = s + 8'($urandom_range(1, 255));
      run_frame(addr, cnt, wq, s, bad, bad ? 8'h15 : 8'h06, aq);
    end

    // stop bit forced low on the third byte of a frame
    clear_obs();
    send_byte(8'hA5, 1'b0);
    send_byte(8'h00, 1'b0);
    send_byte(8'h00, 1'b1);
    wait_resp(400);
    if (tx_q.size() > 0) chk("ferr_resp", tx_q[0], 8'h15);
    chk("ferr_load_err", {31'd0, load_err}, 32'd1);
    chk("ferr_hold", {31'd0, cpu_hold}, 32'd0);
    chk("ferr_no_done", done_cnt, 0);
    chk("ferr_no_writes", wr_a_q.size(), 0);

    // frame stalled after CNT
    clear_obs();
    send_byte(8'hA5, 1'b0);
    send_word(32'h0, 4);
    send_word(32'h1, 2);
`ifdef UART_LOADER_TIMEOUT_EN
    wait_resp(16 * 10 * CPB + 400);
    if (tx_q.size() > 0) chk("timeout_resp", tx_q[0], 8'h15);
    chk("timeout_load_err", {31'd0, load_err}, 32'd1);
    chk("timeout_hold", {31'd0, cpu_hold}, 32'd0);
    chk("timeout_no_done", done_cnt, 0);
`else
    repeat (2500) @(negedge clk);
    chk("stall_hold", {31'd0, cpu_hold}, 32'd1);
    chk("stall_no_tx", tx_q.size(), 0);
    rst = 1'b1;
    repeat (3) @(negedge clk);
    chk("abort_hold", {31'd0, cpu_hold}, 32'd0);
    rst = 1'b0;
    repeat (3) @(negedge clk);
`endif
    wq.delete(); aq.delete();
    wq.push_back(32'hDEADBEEF);
    aq.push_back(14'h0005);
    run_frame(32'h14, 16'd1, wq, frame_sum(32'h14, 16'd1, wq), 1'b0, 8'h06, aq);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #5ms;
    $display("FAIL global_timeout actual=running required=finished");
    $fatal(1);
  end
endmodule
